// File: rtl/fc_layer_ctrl.sv
// Input-vector sequencer for a layer of fc_neuron instances: streams words with ROM addresses,
// issues the bias step, then holds valid_o until the next layer takes it. Optional FC_CTRL_STALL_CNT_EN.
module fc_layer_ctrl #(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int LU_LATENCY            = 1
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [WORD_SIZE-1:0]                       data_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    output logic [$clog2(PREVIOUS_LAYER_HEIGHT+1)-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0]                       data_o,
    output logic                                       sum_en_o,
    output logic                                       add_bias_o,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic                                       busy_o
`ifdef FC_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]                                stall_cnt_o
`endif
);

    localparam int AW = $clog2(PREVIOUS_LAYER_HEIGHT + 1);
    localparam int LW = $clog2(LU_LATENCY + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIAS, S_WAIT, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        count_q, count_d;
    logic [LW-1:0]        wait_q, wait_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 sum_en_q, sum_en_d;
    logic                 add_bias_q, add_bias_d;
    logic                 valid_q, valid_d;
    logic                 hs;

    assign ready_o    = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy_o     = (state_q != S_IDLE);
    assign data_o     = data_q;
    assign sum_en_o   = sum_en_q;
    assign add_bias_o = add_bias_q;
    assign valid_o    = valid_q;
    assign hs         = valid_i & ready_o;

    always_comb begin
        if (ready_o)
            mem_addr_o = count_q;
        else if (state_q == S_BIAS)
            mem_addr_o = AW'(PREVIOUS_LAYER_HEIGHT);
        else
            mem_addr_o = '0;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wait_d     = wait_q;
        data_d     = hs ? data_i : data_q;
        // data/sum_en trail the address by one cycle to line up with the neuron ROM read
        sum_en_d   = hs;
        add_bias_d = 1'b0;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (PREVIOUS_LAYER_HEIGHT == 1) begin
                        state_d = S_BIAS;
                    end else begin
                        state_d = S_LOAD;
                        count_d = AW'(1);
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (count_q == AW'(PREVIOUS_LAYER_HEIGHT - 1)) begin
                        state_d = S_BIAS;
                        count_d = '0;
                    end else begin
                        count_d = count_q + AW'(1);
                    end
                end
            end
            S_BIAS: begin
                state_d    = S_WAIT;
                add_bias_d = 1'b1;
                wait_d     = LW'(LU_LATENCY);
            end
            S_WAIT: begin
                if (wait_q <= LW'(1)) begin
                    state_d = S_OUT;
                    valid_d = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q - LW'(1);
                end
            end
            S_OUT: begin
                valid_d = ~ready_i;
                if (ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FC_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    assign stall_cnt_o = stall_q;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && hs)
            stall_d = '0;
        else if (((state_q == S_LOAD && !valid_i) || (state_q == S_OUT && !ready_i))
                 && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wait_q     <= '0;
            data_q     <= '0;
            sum_en_q   <= 1'b0;
            add_bias_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            data_q     <= data_d;
            sum_en_q   <= sum_en_d;
            add_bias_q <= add_bias_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: unit 0 is H=4/LU=1, unit 1 is H=1/LU=3, both checked every cycle
// against a cycle-arithmetic timeline model plus literal per-scenario expectations.
module tb_fc_layer_ctrl;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        vld [2];
    logic [15:0] dat [2];
    logic        rdy [2];

    logic        ready0, sum0, bias0, valid0, busy0;
    logic        ready1, sum1, bias1, valid1, busy1;
    logic [2:0]  addr0;
    logic [0:0]  addr1;
    logic [15:0] data0, data1;
`ifdef FC_CTRL_STALL_CNT_EN
    logic [15:0] stall0, stall1;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int o_ready [2], o_addr [2], o_data [2], o_sum [2], o_bias [2], o_valid [2], o_busy [2];
    int lg_ready [2][512], lg_addr [2][512], lg_data [2][512];
    int lg_sum [2][512], lg_bias [2][512], lg_valid [2][512];

    int hgt [2] = '{4, 1};
    int lul [2] = '{1, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_ctrl #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4), .LU_LATENCY(1)) u0 (
        .clk_i(clk), .reset_n_i(reset_n_i), .data_i(dat[0]), .valid_i(vld[0]),
        .ready_o(ready0), .mem_addr_o(addr0), .data_o(data0), .sum_en_o(sum0),
        .add_bias_o(bias0), .valid_o(valid0), .ready_i(rdy[0]), .busy_o(busy0)
`ifdef FC_CTRL_STALL_CNT_EN
        , .stall_cnt_o(stall0)
`endif
    );

    fc_layer_ctrl #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1), .LU_LATENCY(3)) u1 (
        .clk_i(clk), .reset_n_i(reset_n_i), .data_i(dat[1]), .valid_i(vld[1]),
        .ready_o(ready1), .mem_addr_o(addr1), .data_o(data1), .sum_en_o(sum1),
        .add_bias_o(bias1), .valid_o(valid1), .ready_i(rdy[1]), .busy_o(busy1)
`ifdef FC_CTRL_STALL_CNT_EN
        , .stall_cnt_o(stall1)
`endif
    );

    always_comb begin
        o_ready[0] = int'(ready0); o_addr[0] = int'(addr0); o_data[0] = int'(data0);
        o_sum[0] = int'(sum0); o_bias[0] = int'(bias0); o_valid[0] = int'(valid0); o_busy[0] = int'(busy0);
        o_ready[1] = int'(ready1); o_addr[1] = int'(addr1); o_data[1] = int'(data1);
        o_sum[1] = int'(sum1); o_bias[1] = int'(bias1); o_valid[1] = int'(valid1); o_busy[1] = int'(busy1);
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: words are counted until H arrive; after the last word at cycle c the
    // bias address appears at c+1, the bias pulse at c+2 and valid from c+2+LU until taken.
    initial begin
        int m_nacc [2], m_done [2], m_prev [2], m_word [2];
        int e_ready, e_addr, e_busy, e_bias, e_valid;
        for (int u = 0; u < 2; u++) begin
            m_nacc[u] = 0; m_done[u] = -1; m_prev[u] = 0; m_word[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (!reset_n_i) begin
                    m_nacc[u] = 0; m_done[u] = -1; m_prev[u] = 0; m_word[u] = 0;
                end else begin
                    if (m_done[u] < 0) begin
                        e_ready = 1; e_addr = m_nacc[u]; e_busy = (m_nacc[u] > 0) ? 1 : 0;
                        e_bias = 0; e_valid = 0;
                    end else begin
                        e_ready = 0; e_busy = 1;
                        e_addr  = (cyc == m_done[u] + 1) ? hgt[u] : 0;
                        e_bias  = (cyc == m_done[u] + 2) ? 1 : 0;
                        e_valid = (cyc >= m_done[u] + 2 + lul[u]) ? 1 : 0;
                    end
                    chk($sformatf("u%0d ready_o", u), o_ready[u], e_ready);
                    chk($sformatf("u%0d mem_addr_o", u), o_addr[u], e_addr);
                    chk($sformatf("u%0d busy_o", u), o_busy[u], e_busy);
                    chk($sformatf("u%0d add_bias_o", u), o_bias[u], e_bias);
                    chk($sformatf("u%0d valid_o", u), o_valid[u], e_valid);
                    chk($sformatf("u%0d sum_en_o", u), o_sum[u], m_prev[u]);
                    chk($sformatf("u%0d data_o", u), o_data[u], m_word[u]);
                    if (cyc < 512) begin
                        lg_ready[u][cyc] = o_ready[u]; lg_addr[u][cyc] = o_addr[u];
                        lg_data[u][cyc] = o_data[u]; lg_sum[u][cyc] = o_sum[u];
                        lg_bias[u][cyc] = o_bias[u]; lg_valid[u][cyc] = o_valid[u];
                    end
                    m_prev[u] = (vld[u] && e_ready == 1) ? 1 : 0;
                    if (m_prev[u] == 1) begin
                        m_word[u] = int'(dat[u]);
                        m_nacc[u]++;
                        if (m_nacc[u] == hgt[u]) begin
                            m_done[u] = cyc;
                            m_nacc[u] = 0;
                        end
                    end
                    if (e_valid == 1 && rdy[u])
                        m_done[u] = -1;
                end
            end
        end
    end

    task automatic step(int u, bit v, int d, bit r);
        vld[u] = v; dat[u] = 16'(d); rdy[u] = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int u, int n, bit r);
        for (int i = 0; i < n; i++) step(u, 1'b0, 0, r);
    endtask

    task automatic full_vector_checks(string tag, int b);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s addr c%0d", tag, k), lg_addr[0][b+k], k);
            chk($sformatf("%s sum_en c%0d", tag, k+1), lg_sum[0][b+k+1], 1);
            chk($sformatf("%s data c%0d", tag, k+1), lg_data[0][b+k+1], k+1);
        end
        chk({tag, " addr bias"}, lg_addr[0][b+4], 4);
        chk({tag, " add_bias c5"}, lg_bias[0][b+5], 1);
        chk({tag, " sum_en c5"}, lg_sum[0][b+5], 0);
        chk({tag, " valid c5"}, lg_valid[0][b+5], 0);
        chk({tag, " valid c6"}, lg_valid[0][b+6], 1);
        chk({tag, " valid c7"}, lg_valid[0][b+7], 0);
        chk({tag, " ready c7"}, lg_ready[0][b+7], 1);
    endtask

    initial begin
        int b;
        for (int u = 0; u < 2; u++) begin
            vld[u] = 1'b0; dat[u] = '0; rdy[u] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset ready_o", int'(ready0), 1);
        chk("reset valid_o", int'(valid0), 0);
        chk("reset busy_o", int'(busy0), 0);
        reset_n_i = 1'b1;
        idle(0, 2, 1'b1);

        // back-to-back vector, downstream always ready
        b = cyc;
        for (int k = 1; k <= 4; k++) step(0, 1'b1, k, 1'b1);
        idle(0, 5, 1'b1);
        full_vector_checks("s1", b);
        $display("s1 back-to-back vector done at cycle %0d", cyc);

        // bubble on valid_i in cycle 2
        b = cyc;
        step(0, 1'b1, 10, 1'b1); step(0, 1'b1, 20, 1'b1); step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 30, 1'b1); step(0, 1'b1, 40, 1'b1);
        idle(0, 5, 1'b1);
        chk("s2 addr holds c2", lg_addr[0][b+2], 2);
        chk("s2 sum_en low c3", lg_sum[0][b+3], 0);
        chk("s2 data holds c3", lg_data[0][b+3], 20);
        chk("s2 add_bias c6", lg_bias[0][b+6], 1);
        chk("s2 add_bias c5", lg_bias[0][b+5], 0);
        $display("s2 valid_i bubble vector done at cycle %0d", cyc);

        // downstream stall: ready_i low cycles 0-9, high at 10
        b = cyc;
        for (int k = 1; k <= 4; k++) step(0, 1'b1, k, 1'b0);
        idle(0, 6, 1'b0);
        idle(0, 3, 1'b1);
        for (int k = 6; k <= 10; k++) chk($sformatf("s3 valid c%0d", k), lg_valid[0][b+k], 1);
        for (int k = 4; k <= 10; k++) chk($sformatf("s3 ready_o c%0d", k), lg_ready[0][b+k], 0);
        chk("s3 ready_o c11", lg_ready[0][b+11], 1);
        chk("s3 valid c11", lg_valid[0][b+11], 0);
        $display("s3 downstream stall vector done at cycle %0d", cyc);

        // asynchronous reset after two words
        step(0, 1'b1, 5, 1'b1); step(0, 1'b1, 6, 1'b1);
        vld[0] = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        chk("s4 async ready_o", int'(ready0), 1);
        chk("s4 async sum_en_o", int'(sum0), 0);
        chk("s4 async data_o", int'(data0), 0);
        chk("s4 async mem_addr_o", int'(addr0), 0);
        chk("s4 async busy_o", int'(busy0), 0);
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        idle(0, 2, 1'b1);
        b = cyc;
        for (int k = 1; k <= 4; k++) step(0, 1'b1, k, 1'b1);
        idle(0, 5, 1'b1);
        full_vector_checks("s4", b);
        $display("s4 reset abort and recovery vector done at cycle %0d", cyc);

        // H=1, LU_LATENCY=3 unit
        b = cyc;
        step(1, 1'b1, 7, 1'b1);
        idle(1, 7, 1'b1);
        chk("s5 sum_en c1", lg_sum[1][b+1], 1);
        chk("s5 data c1", lg_data[1][b+1], 7);
        chk("s5 addr c1", lg_addr[1][b+1], 1);
        chk("s5 add_bias c2", lg_bias[1][b+2], 1);
        chk("s5 valid c4", lg_valid[1][b+4], 0);
        chk("s5 valid c5", lg_valid[1][b+5], 1);
        chk("s5 valid c6", lg_valid[1][b+6], 0);
        $display("s5 H=1 LU=3 vector done at cycle %0d", cyc);

`ifdef FC_CTRL_STALL_CNT_EN
        // one LOAD bubble plus four OUT stall cycles
        step(0, 1'b1, 1, 1'b0); step(0, 1'b1, 2, 1'b0); step(0, 1'b0, 0, 1'b0);
        step(0, 1'b1, 3, 1'b0); step(0, 1'b1, 4, 1'b0);
        idle(0, 6, 1'b0);
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("s6 valid_o at take", int'(valid0), 1);
        chk("s6 stall_cnt_o", int'(stall0), 5);
        @(posedge clk);
        #1;
        idle(0, 3, 1'b1);
        $display("s6 stall counter vector done at cycle %0d", cyc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
